// File: rtl/sha256_compress_core_if.sv
// Block-in / digest-out bundle for sha256_compress_core. With SHA256_COMPRESS_SHA224_EN
// defined the bundle also carries mode224.
interface sha256_compress_core_if;
    // Handshakes: a transfer happens on a clk edge where valid && ready are both high.
    // Producers hold data stable while valid is high and not yet taken.
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef SHA256_COMPRESS_SHA224_EN
    logic         mode224;
`endif

    modport master (
`ifdef SHA256_COMPRESS_SHA224_EN
        output mode224,
`endif
        output blk_valid, blk_data, blk_first, blk_last, digest_ready,
        input  blk_ready, digest_valid, digest, busy, dbg_state
    );

    modport slave (
`ifdef SHA256_COMPRESS_SHA224_EN
        input  mode224,
`endif
        input  blk_valid, blk_data, blk_first, blk_last, digest_ready,
        output blk_ready, digest_valid, digest, busy, dbg_state
    );
endinterface

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression with ROUNDS_PER_CYCLE chained rounds per clock.
// Optional SHA-224 mode under SHA256_COMPRESS_SHA224_EN.
module sha256_compress_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_compress_core_if.slave  io
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam int N = 64 / R;
    localparam logic [5:0] LAST_CNT = 6'(N - 1);

    generate
        if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_COMPRESS_SHA224_EN
    localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic [0:7][31:0]   h_q, v_q, v_nxt;
    logic [0:15][31:0]  w_q, w_nxt;
    logic               last_q;
    logic [255:0]       iv_sel, dig;
    logic               accept;
`ifdef SHA256_COMPRESS_SHA224_EN
    logic               mode_q;
    assign iv_sel = io.mode224 ? IV224 : IV256;
`else
    assign iv_sel = IV256;
`endif

    assign accept          = io.blk_valid && io.blk_ready;
    assign io.blk_ready    = (state == IDLE) && !rst;
    assign io.digest_valid = (state == DONE);
    assign io.busy         = (state != IDLE);
    assign io.dbg_state    = state;

    always_comb begin
        dig = h_q;
`ifdef SHA256_COMPRESS_SHA224_EN
        if (mode_q) dig[31:0] = 32'h0;
`endif
    end
    assign io.digest = (state == DONE) ? dig : '0;

    // ext[16..23] extends the window so that up to eight rounds see their Wt this cycle.
    always_comb begin : round_c
        logic [31:0] ext [0:23];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        logic [5:0]  idx;
        t1  = '0;
        t2  = '0;
        idx = '0;
        for (int k = 0; k < 16; k++) ext[k] = w_q[k];
        for (int k = 16; k < 24; k++)
            ext[k] = ssig1(ext[k-2]) + ext[k-7] + ssig0(ext[k-15]) + ext[k-16];
        {a, b, c, d, e, f, g, hh} = v_q;
        for (int i = 0; i < R; i++) begin
            idx = 6'(int'(cnt) * R + i);
            t1  = hh + bsig1(e) + ((e & f) ^ (~e & g)) + K[idx] + ext[i];
            t2  = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d  = c; c = b; b = a; a = t1 + t2;
        end
        v_nxt = {a, b, c, d, e, f, g, hh};
        for (int k = 0; k < 16; k++) w_nxt[k] = ext[k+R];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            h_q    <= '0;
            v_q    <= '0;
            w_q    <= '0;
            last_q <= 1'b0;
`ifdef SHA256_COMPRESS_SHA224_EN
            mode_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    w_q    <= io.blk_data;
                    last_q <= io.blk_last;
                    cnt    <= '0;
                    state  <= ROUND;
                    if (io.blk_first) begin
                        h_q <= iv_sel;
                        v_q <= iv_sel;
`ifdef SHA256_COMPRESS_SHA224_EN
                        mode_q <= io.mode224;
`endif
                    end else begin
                        v_q <= h_q;
                    end
                end
                ROUND: begin
                    v_q <= v_nxt;
                    w_q <= w_nxt;
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= FINAL;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    state <= last_q ? DONE : IDLE;
                end
                DONE: if (io.digest_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_compress_core.sv
// Drives four cores (1, 2, 4, 8 rounds per clock) in lockstep and checks digests and
// latencies against known vectors and a full-schedule SHA-256 reference model.
module tb_sha256_compress_core;
  localparam int NDUT = 4;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KC [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         blk_valid, blk_first, blk_last;
  logic [511:0] blk_data;
  logic         blk_ready_v    [NDUT];
  logic         digest_valid_v [NDUT];
  logic         digest_ready_v [NDUT];
  logic         busy_v         [NDUT];
  logic [255:0] digest_v       [NDUT];
  logic [1:0]   state_v        [NDUT];
`ifdef SHA256_COMPRESS_SHA224_EN
  logic         mode224;
`endif

  for (genvar g = 0; g < NDUT; g++) begin : dut_g
    sha256_compress_core_if bus ();
    assign bus.blk_valid    = blk_valid;
    assign bus.blk_data     = blk_data;
    assign bus.blk_first    = blk_first;
    assign bus.blk_last     = blk_last;
    assign bus.digest_ready = digest_ready_v[g];
`ifdef SHA256_COMPRESS_SHA224_EN
    assign bus.mode224      = mode224;
`endif
    assign blk_ready_v[g]    = bus.blk_ready;
    assign digest_valid_v[g] = bus.digest_valid;
    assign busy_v[g]         = bus.busy;
    assign digest_v[g]       = bus.digest;
    assign state_v[g]        = bus.dbg_state;
    sha256_compress_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
    );
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [255:0] exp_q [$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: straight FIPS 180-4 compression with a full 64-word schedule
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [255:0] out;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KC[t] + w[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + s[i];
    return out;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // drivers (inputs change on negedge, outputs sampled on negedge)
  task automatic set_ready_all(input logic v);
    for (int g = 0; g < NDUT; g++) digest_ready_v[g] = v;
  endtask

  task automatic wait_all_ready();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      ok = 1'b1;
      for (int g = 0; g < NDUT; g++) if (blk_ready_v[g] !== 1'b1) ok = 1'b0;
      if (!ok) @(negedge clk);
    end
    if (!ok) check("ready_timeout", 256'(0), 256'(1));
  endtask

  task automatic send_block(input logic [511:0] d, input logic f, input logic l, output int acc);
    wait_all_ready();
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    @(negedge clk);
    acc       = cyc;
    blk_valid = 1'b0;
    blk_data  = rand_blk();
    blk_first = 1'($urandom_range(0, 1));
    blk_last  = 1'($urandom_range(0, 1));
    for (int g = 0; g < NDUT; g++) check($sformatf("busy_after_accept_r%0d", 1 << g), 256'(busy_v[g]), 256'(1));
  endtask

  // offers a block and checks when each core shows a digest (last) or readiness (not last)
  task automatic run_block(input logic [511:0] d, input logic f, input logic l);
    int acc;
    int lat [NDUT];
    bit seen [NDUT];
    bit all_seen;
    for (int g = 0; g < NDUT; g++) begin lat[g] = 0; seen[g] = 1'b0; end
    send_block(d, f, l, acc);
    all_seen = 1'b0;
    for (int c = 0; c < 100 && !all_seen; c++) begin
      @(negedge clk);
      all_seen = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (!seen[g] && (l ? digest_valid_v[g] : blk_ready_v[g]) === 1'b1) begin
          seen[g] = 1'b1;
          lat[g]  = cyc - acc;
        end
        if (!seen[g]) all_seen = 1'b0;
      end
    end
    for (int g = 0; g < NDUT; g++)
      check($sformatf("%s_latency_r%0d", l ? "digest" : "ready", 1 << g), 256'(lat[g]), 256'(64 / (1 << g) + 1));
  endtask

  task automatic take_digest(input string tag, input logic [255:0] exp);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s_valid_r%0d", tag, 1 << g), 256'(digest_valid_v[g]), 256'(1));
      check($sformatf("%s_digest_r%0d", tag, 1 << g), digest_v[g], exp);
    end
    set_ready_all(1'b1);
    @(negedge clk);
    set_ready_all(1'b0);
    for (int g = 0; g < NDUT; g++)
      check($sformatf("%s_valid_drop_r%0d", tag, 1 << g), 256'(digest_valid_v[g]), 256'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] h;
    logic [511:0] d;
    int acc;
    int nblk;
    rst       = 1'b1;
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    blk_data  = '0;
    set_ready_all(1'b0);
`ifdef SHA256_COMPRESS_SHA224_EN
    mode224 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    blk_valid = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_blk_ready_r%0d", 1 << g), 256'(blk_ready_v[g]), 256'(0));
      check($sformatf("rst_busy_r%0d", 1 << g), 256'(busy_v[g]), 256'(0));
      check($sformatf("rst_digest_valid_r%0d", 1 << g), 256'(digest_valid_v[g]), 256'(0));
      check($sformatf("rst_digest_r%0d", 1 << g), digest_v[g], 256'(0));
    end
    blk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_block(ABC_BLK, 1'b1, 1'b1);
    take_digest("abc", ABC_DIG);

    run_block(EMPTY_BLK, 1'b1, 1'b1);
    take_digest("empty", EMPTY_DIG);

    run_block(TWO_BLK1, 1'b1, 1'b0);
    run_block(TWO_BLK2, 1'b0, 1'b1);
    take_digest("two_block", TWO_DIG);

    // backpressure: digest held, then an offered block must be refused
    run_block(ABC_BLK, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("bp_digest_r%0d", 1 << g), digest_v[g], ABC_DIG);
        check($sformatf("bp_blk_ready_r%0d", 1 << g), 256'(blk_ready_v[g]), 256'(0));
      end
    end
    blk_valid = 1'b1;
    blk_first = 1'b1;
    blk_last  = 1'b1;
    blk_data  = rand_blk();
    repeat (3) @(negedge clk);
    blk_valid = 1'b0;
    for (int g = 0; g < NDUT; g++)
      check($sformatf("bp_refused_state_r%0d", 1 << g), 256'(busy_v[g] && !blk_ready_v[g]), 256'(1));
    take_digest("bp", ABC_DIG);

    // reset in the middle of a block
    send_block(ABC_BLK, 1'b1, 1'b1, acc);
    repeat (30) @(negedge clk);
    pulse_reset();
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("midrst_busy_r%0d", 1 << g), 256'(busy_v[g]), 256'(0));
      check($sformatf("midrst_valid_r%0d", 1 << g), 256'(digest_valid_v[g]), 256'(0));
      check($sformatf("midrst_blk_ready_r%0d", 1 << g), 256'(blk_ready_v[g]), 256'(1));
    end
    run_block(ABC_BLK, 1'b1, 1'b1);
    take_digest("abc_after_rst", ABC_DIG);

    // first block after reset without blk_first hashes from H = 0
    pulse_reset();
    d = rand_blk();
    run_block(d, 1'b0, 1'b1);
    take_digest("no_first", compress(256'(0), d));

    // random multi-block messages; digest_ready noise during non-last blocks is ignored
    for (int m = 0; m < 6; m++) begin
      nblk = $urandom_range(1, 3);
      h = IV256;
      for (int b = 0; b < nblk; b++) begin
        d = rand_blk();
        h = compress(h, d);
        set_ready_all(1'(b != nblk - 1 ? $urandom_range(0, 1) : 0));
        run_block(d, 1'(b == 0), 1'(b == nblk - 1));
      end
      exp_q.push_back(h);
      take_digest($sformatf("rand_msg%0d", m), exp_q.pop_front());
    end

`ifdef SHA256_COMPRESS_SHA224_EN
    mode224 = 1'b1;
    run_block(ABC_BLK, 1'b1, 1'b1);
    mode224 = 1'b0;
    take_digest("sha224_abc", 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
    run_block(ABC_BLK, 1'b1, 1'b1);
    take_digest("abc_after_224", ABC_DIG);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
